// File: rtl/alu_4bit_resp.sv
// alu_4bit_resp: 4-bit add/sub/and/or ALU with a valid/ready request side and
// a 2-entry in-order result buffer on the response side.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (a, b, op sampled on accept)
//   a, b               4-bit operands
//   op                 00 add, 01 sub, 10 and, 11 or
//   out_valid/out_ready response handshake for the buffer head
//   f, carry, zero     head result and its flags (all 0 while out_valid is 0)
//   op_count           accepted-request count, saturating at 8'hFF
//
// Configuration:
//   ALU_RESP_FLAGS_EN  defined: carry/zero computed and buffered with f.
//                      undefined: carry/zero tied to 0, no flag storage.
module alu_4bit_resp (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] f,
    output logic       carry,
    output logic       zero,
    output logic [7:0] op_count
);

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned COUNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [DATA_W-1:0] f;
`ifdef ALU_RESP_FLAGS_EN
        logic              carry;
        logic              zero;
`endif
    } entry_t;

    occ_t               state_q, state_d;
    entry_t             head_q, head_d;
    entry_t             tail_q, tail_d;
    entry_t             res;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [COUNT_W-1:0] op_count_q, op_count_d;
    logic               push, pop;

    // Result of the request currently presented on a/b/op.
    always_comb begin
        res   = '0;
        case (op)
            2'b00:   res.f = a + b;
            2'b01:   res.f = a - b;
            2'b10:   res.f = a & b;
            default: res.f = a | b;
        endcase
`ifdef ALU_RESP_FLAGS_EN
        case (op)
            2'b00:   res.carry = 5'({1'b0, a} + {1'b0, b}) >= 5'd16;
            2'b01:   res.carry = (a >= b);
            default: res.carry = 1'b0;
        endcase
        res.zero = (res.f == 4'h0);
`endif
    end

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Occupancy next-state and buffer moves; a vacated head is cleared so
    // the head outputs read 0 whenever nothing is valid.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        op_count_d = op_count_q;

        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = res;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = res;
                end else if (push) begin
                    tail_d  = res;
                    state_d = FULL;
                end else if (pop) begin
                    head_d  = '0;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = ONE;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                state_d = EMPTY;
            end
        endcase

        if (push && (op_count_q != 8'hFF)) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    // State and registered outputs; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f         = head_q.f;
    assign op_count  = op_count_q;
`ifdef ALU_RESP_FLAGS_EN
    assign carry     = head_q.carry;
    assign zero      = head_q.zero;
`else
    assign carry     = 1'b0;
    assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_4bit_resp.sv
// Self-checking bench for alu_4bit_resp: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_alu_4bit_resp;

`ifdef ALU_RESP_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] f;
    logic       carry;
    logic       zero;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;

    // Model state: expected buffer contents {carry, zero, f} and count.
    logic [5:0] mq[$];
    int         mcount;

    alu_4bit_resp dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .carry     (carry),
        .zero      (zero),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ref_alu(input int ia, input int ib, input int iop);
        int  rf;
        bit  rc;
        rc = 1'b0;
        case (iop)
            0: begin rf = (ia + ib) % 16; rc = (ia + ib) >= 16; end
            1: begin rf = (ia - ib + 16) % 16; rc = (ia >= ib); end
            2: rf = ia & ib;
            default: rf = ia | ib;
        endcase
        return {rc, (rf == 0), 4'(rf)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare outputs.
    task automatic cyc(input logic r, input logic v, input logic [3:0] ta,
                       input logic [3:0] tb, input logic [1:0] top, input logic ordy);
        bit         acc;
        bit         pp;
        logic [5:0] h;
        rst       = r;
        in_valid  = v;
        a         = ta;
        b         = tb;
        op        = top;
        out_ready = ordy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mcount = 0;
        end else begin
            acc = v && (mq.size() < 2);
            pp  = ordy && (mq.size() > 0);
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(ref_alu(int'(ta), int'(tb), int'(top)));
                if (mcount < 255) mcount++;
            end
        end
        #1;
        h = (mq.size() > 0) ? mq[0] : 6'd0;
        chk("in_ready",  8'(in_ready),  8'(mq.size() < 2));
        chk("out_valid", 8'(out_valid), 8'(mq.size() > 0));
        chk("f",         8'(f),         8'(h[3:0]));
        chk("carry",     8'(carry),     8'(FLAGS & h[5]));
        chk("zero",      8'(zero),      8'(FLAGS & h[4]));
        chk("op_count",  op_count,      8'(mcount));
    endtask

    initial begin
        mcount = 0;
        // Reset
        cyc(1, 1, 4'h3, 4'h4, 2'b00, 1);
        cyc(1, 0, 4'h0, 4'h0, 2'b00, 0);
        chk("reset_in_ready", 8'(in_ready), 8'd1);

        // Basic operations with the consumer always ready
        cyc(0, 1, 4'h2, 4'h6, 2'b00, 1);
        chk("add_2_6", 8'(f), 8'd8);
        cyc(0, 1, 4'h2, 4'h1, 2'b01, 1);
        chk("sub_2_1", 8'(f), 8'd1);
        cyc(0, 1, 4'h2, 4'h6, 2'b10, 1);
        chk("and_2_6", 8'(f), 8'd2);
        cyc(0, 1, 4'h2, 4'h6, 2'b11, 1);
        chk("or_2_6", 8'(f), 8'd6);
        cyc(0, 1, 4'hF, 4'h1, 2'b00, 1);
        chk("add_f_1", 8'(f), 8'd0);
        cyc(0, 1, 4'h1, 4'h2, 2'b01, 1);
        chk("sub_1_2", 8'(f), 8'hF);
        cyc(0, 0, 4'h0, 4'h0, 2'b00, 1);
        chk("drained", 8'(out_valid), 8'd0);

        // Back-pressure: fill, third request ignored, then drain in order
        cyc(1, 0, 4'h0, 4'h0, 2'b00, 0);
        cyc(0, 1, 4'h5, 4'h3, 2'b00, 0);
        cyc(0, 1, 4'h9, 4'h4, 2'b01, 0);
        chk("full_in_ready", 8'(in_ready), 8'd0);
        cyc(0, 1, 4'h7, 4'h7, 2'b11, 0);
        chk("ignored_count", op_count, 8'd2);
        cyc(0, 0, 4'h0, 4'h0, 2'b00, 1);
        chk("drain_first", 8'(f), 8'd5);
        cyc(0, 0, 4'h0, 4'h0, 2'b00, 1);
        chk("drain_empty", 8'(out_valid), 8'd0);

        // Push and pop together while holding one entry
        cyc(0, 1, 4'h3, 4'h3, 2'b01, 0);
        cyc(0, 1, 4'hA, 4'h5, 2'b11, 1);
        chk("pushpop_head", 8'(f), 8'hF);
        cyc(0, 0, 4'h0, 4'h0, 2'b00, 1);

        // Reset while full discards everything
        cyc(0, 1, 4'h1, 4'h1, 2'b00, 0);
        cyc(0, 1, 4'h2, 4'h2, 2'b00, 0);
        cyc(1, 1, 4'h4, 4'h4, 2'b00, 1);
        chk("rst_full_valid", 8'(out_valid), 8'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'h0, 4'h0, 2'b00, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                4'($urandom), 4'($urandom), 2'($urandom), ($urandom_range(0, 2) != 0));
        end

        // Counter saturation
        cyc(1, 0, 4'h0, 4'h0, 2'b00, 1);
        for (int i = 0; i < 260; i++) begin
            cyc(0, 1, 4'($urandom), 4'($urandom), 2'($urandom), 1);
        end
        chk("op_count_sat", op_count, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
